// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice per clock, LSB nibble first.
// Optional NSA_OVF_EN adds a registered two's-complement overflow output (ovf).
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef NSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [WIDTH-1:0] a_q, b_q;
    logic            carry;

    logic [3:0] an, bn, g, p, s;
    logic       c1, c2, c3, c4;

    // Full lookahead form: every carry is built from g/p and the slice carry-in only.
    always_comb begin
        an = a_q[4*idx +: 4];
        bn = b_q[4*idx +: 4];
        g  = an & bn;
        p  = an ^ bn;
        c1 = g[0] | (p[0] & carry);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & carry);
        s  = p ^ {c3, c2, c1, carry};
    end

    assign in_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef NSA_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[4*idx +: 4] <= s;
                    carry           <= c4;
                    if (idx == LAST) begin
                        cout      <= c4;
`ifdef NSA_OVF_EN
                        ovf       <= c3 ^ c4;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against an arithmetic latency model.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, cout, busy;
    logic [W-1:0] sum;
`ifdef NSA_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;
    int results = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
`ifdef NSA_OVF_EN
        , .ovf(ovf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: -1 = waiting for operands, >0 = edges left until result, 0 = result presented.
    int           m_left = -1;
    logic [W:0]   m_res = '0;
    logic         m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = -1;
        end else if (m_left < 0) begin
            if (in_valid) begin
                m_res  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_ovf  = (a[W-1] == b[W-1]) && (m_res[W-1] != a[W-1]);
                m_left = N;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (out_ready) begin
            m_left = -1;
            results++;
        end
    end

    always @(negedge clk) begin
        chk("mon_in_ready", {31'b0, in_ready}, {31'b0, rst_n && (m_left < 0)});
        chk("mon_busy", {31'b0, busy}, {31'b0, m_left >= 0});
        chk("mon_out_valid", {31'b0, out_valid}, {31'b0, m_left == 0});
        if (m_left == 0) begin
            chk("mon_sum", {16'b0, sum}, {16'b0, m_res[W-1:0]});
            chk("mon_cout", {31'b0, cout}, {31'b0, m_res[W]});
`ifdef NSA_OVF_EN
            chk("mon_ovf", {31'b0, ovf}, {31'b0, m_ovf});
`endif
        end
    end

    // Called at posedge+2; returns at posedge+2 of the first cycle with out_valid high.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic hold, output int lat);
        int n;
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        out_ready = !hold;
        @(posedge clk); #2;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
    endtask

    initial begin
        int lat;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {16'b0, sum}, 32'h0000);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        op(16'h0000, 16'h0001, 1'b0, 1'b0, lat);
        chk("simple_latency", lat, 32'd4);
        chk("simple_sum", {16'b0, sum}, 32'h0001);
        chk("simple_cout", {31'b0, cout}, 32'd0);
`ifdef NSA_OVF_EN
        chk("simple_ovf", {31'b0, ovf}, 32'd0);
`endif

        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("fullcarry_latency", lat, 32'd4);
        chk("fullcarry_sum", {16'b0, sum}, 32'h0000);
        chk("fullcarry_cout", {31'b0, cout}, 32'd1);
`ifdef NSA_OVF_EN
        chk("fullcarry_ovf", {31'b0, ovf}, 32'd0);
`endif

        op(16'h8888, 16'h8888, 1'b1, 1'b0, lat);
        chk("nibcarry_sum", {16'b0, sum}, 32'h1111);
        chk("nibcarry_cout", {31'b0, cout}, 32'd1);
`ifdef NSA_OVF_EN
        chk("nibcarry_ovf", {31'b0, ovf}, 32'd1);
`endif

        op(16'h00F0, 16'h0010, 1'b0, 1'b1, lat);
        chk("bp_latency", lat, 32'd4);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(posedge clk); #2;
            chk("bp_sum_held", {16'b0, sum}, 32'h0100);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);

        a = 16'hABCD; b = 16'h5678; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_sum", {16'b0, sum}, 32'h0000);
        chk("midrst_cout", {31'b0, cout}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #2;
        op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        chk("after_rst_latency", lat, 32'd4);
        chk("after_rst_sum", {16'b0, sum}, 32'h5555);
        chk("after_rst_cout", {31'b0, cout}, 32'd0);

        results = 0;
        repeat (1500) begin
            @(posedge clk); #2;
            in_valid  = 1'($urandom);
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (N + 3) @(posedge clk);
        #2;
        chk("random_results_seen", {31'b0, results >= 50}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog timeout");
    end

endmodule
